color_blob_tracker: RTL and testbench

COLOR_BLOB_TRACKER -- requirements
Module: color_blob_tracker

---
 rtl/color_blob_tracker_pkg.sv | 43 ++++
 rtl/mask_line_buffer.sv | 39 +++
 rtl/color_blob_tracker.sv | 182 ++++++++++++++++++
 tb/tb_color_blob_tracker.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/color_blob_tracker_pkg.sv
// Shared types and helpers for the colour blob tracker: FSM encoding, coordinate widths,
// default-centre helpers and the masked 3x3 vote count.
package color_blob_tracker_pkg;

   localparam int X_W = 10;
   localparam int Y_W = 9;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_ACTIVE = 480;

   typedef enum logic [1:0] {
      START_UP = 2'd0,
      WAIT     = 2'd1,
      ACTIVE   = 2'd2
   } state_t;

   function automatic logic [X_W-1:0] center_x(input int h_active);
      return X_W'(h_active / 2);
   endfunction

   function automatic logic [Y_W-1:0] center_y(input int v_active);
      return Y_W'(v_active / 2);
   endfunction

   // c0 is the newest column, c2 the oldest; bit r of a column is line (current - r).
   function automatic logic [3:0] vote_sum(
      input logic [2:0] c0,
      input logic [2:0] c1,
      input logic [2:0] c2,
      input logic [2:0] row_ok,
      input logic [2:0] col_ok
   );
      logic [3:0] s;
      s = '0;
      for (int r = 0; r < 3; r++) begin
         s = s + {3'b000, c0[r] & row_ok[r] & col_ok[0]}
               + {3'b000, c1[r] & row_ok[r] & col_ok[1]}
               + {3'b000, c2[r] & row_ok[r] & col_ok[2]};
      end
      return s;
   endfunction

endpackage

// File: rtl/mask_line_buffer.sv
// Two-line mask buffer: returns the current pixel and the same column of the two previous lines.
// Reads are asynchronous; writes happen on every active pixel.
module mask_line_buffer #(
   parameter int NUM_CH   = 2,
   parameter int H_ACTIVE = 640
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [9:0]        col,
   input  logic [NUM_CH-1:0] din,
   output logic [NUM_CH-1:0] tap0,
   output logic [NUM_CH-1:0] tap1,
   output logic [NUM_CH-1:0] tap2
);

   localparam int         AW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);

   logic [NUM_CH-1:0] line1 [H_ACTIVE];
   logic [NUM_CH-1:0] line2 [H_ACTIVE];
   logic              in_range;
   logic [AW-1:0]     addr;

   assign in_range = (col <= H_LAST);
   assign addr     = in_range ? col[AW-1:0] : '0;

   // The older line takes the previous contents of the newer one at the same column.
   always_ff @(posedge clk) begin
      if (wr_en && in_range) begin
         line2[addr] <= line1[addr];
         line1[addr] <= din;
      end
   end

   assign tap0 = din;
   assign tap1 = line1[addr];
   assign tap2 = line2[addr];

endmodule

// File: rtl/color_blob_tracker.sv
// Per-channel blob tracker: 3x3 majority vote on a mask stream and a per-frame longest-run search.
// Filtered mask is combinational; frame results latch one cycle after the frame ends.
module color_blob_tracker
   import color_blob_tracker_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int VOTE_THRESH = 5,
   parameter int MIN_RUN     = 4
) (
   input  logic                  iVgaClk,
   input  logic                  reset,
   input  logic [NUM_CH-1:0]     iMask,
   input  logic [9:0]            iHIndex,
   input  logic [8:0]            iVIndex,
   input  logic                  iVgaHRequest,
   input  logic                  iVgaVRequest,
   input  logic [NUM_CH-1:0]     iFilterOn,
   output logic [NUM_CH-1:0]     oFiltMask,
   output logic [10*NUM_CH-1:0]  oCenterX,
   output logic [9*NUM_CH-1:0]   oCenterY,
   output logic [10*NUM_CH-1:0]  oRunLen,
   output logic [NUM_CH-1:0]     oFound,
   output logic                  oFrameDone
);

   localparam logic [X_W-1:0] DEF_X   = center_x(H_ACTIVE);
   localparam logic [Y_W-1:0] DEF_Y   = center_y(V_ACTIVE);
   localparam logic [X_W-1:0] RUN_SAT = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] MIN_LEN = X_W'(MIN_RUN);
   localparam logic [3:0]     THRESH  = 4'(VOTE_THRESH);

   logic                       pix_vld;
   logic [NUM_CH-1:0]          tap0, tap1, tap2;
   logic [NUM_CH-1:0][2:0]     col1_q, col2_q;
   logic [2:0]                 row_ok, col_ok;
   logic [NUM_CH-1:0]          filt;
   logic [X_W-1:0]             rep_x;
   logic [Y_W-1:0]             rep_y;

   state_t                     state;
   logic                       vreq_q;
   logic [NUM_CH-1:0][X_W-1:0] run_q, run_nxt, max_q, end_x_q, cx_q, len_q;
   logic [NUM_CH-1:0][Y_W-1:0] line_q, cy_q;
   logic [NUM_CH-1:0]          found_q;
   logic                       done_q;

   assign pix_vld = iVgaHRequest & iVgaVRequest;

   mask_line_buffer #(
      .NUM_CH   (NUM_CH),
      .H_ACTIVE (H_ACTIVE)
   ) u_line_buf (
      .clk   (iVgaClk),
      .wr_en (pix_vld),
      .col   (iHIndex),
      .din   (iMask),
      .tap0  (tap0),
      .tap1  (tap1),
      .tap2  (tap2)
   );

   // Window columns are left unreset; the line/column masks hide stale contents.
   always_ff @(posedge iVgaClk) begin
      if (pix_vld) begin
         for (int k = 0; k < NUM_CH; k++) begin
            col1_q[k] <= {tap2[k], tap1[k], tap0[k]};
            col2_q[k] <= col1_q[k];
         end
      end
   end

   // Row r holds line iVIndex-r, column d holds pixel iHIndex-d; lines/columns 0 and 1 never vote.
   always_comb begin
      row_ok[0] = (iVIndex >= 9'd2);
      row_ok[1] = (iVIndex >= 9'd3);
      row_ok[2] = (iVIndex >= 9'd4);
      col_ok[0] = (iHIndex >= 10'd2);
      col_ok[1] = (iHIndex >= 10'd3);
      col_ok[2] = (iHIndex >= 10'd4);
   end

   assign rep_x = (iHIndex == '0) ? '0 : iHIndex - 10'd1;
   assign rep_y = (iVIndex == '0) ? '0 : iVIndex - 9'd1;

   always_comb begin
      filt    = '0;
      run_nxt = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (iFilterOn[k])
            filt[k] = (vote_sum({tap2[k], tap1[k], tap0[k]}, col1_q[k], col2_q[k],
                                row_ok, col_ok) >= THRESH);
         else
            filt[k] = col1_q[k][1] & (iVIndex != '0);
         if (filt[k])
            run_nxt[k] = (run_q[k] == RUN_SAT) ? run_q[k] : run_q[k] + 10'd1;
      end
   end

   assign oFiltMask = filt;

   // Starting only on a VRequest rising edge drops a frame that was cut by reset.
   always_ff @(posedge iVgaClk) begin
      if (reset) begin
         state   <= START_UP;
         vreq_q  <= 1'b1;
         done_q  <= 1'b0;
         found_q <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            run_q[k]   <= '0;
            max_q[k]   <= '0;
            end_x_q[k] <= '0;
            line_q[k]  <= DEF_Y;
            cx_q[k]    <= DEF_X;
            cy_q[k]    <= DEF_Y;
            len_q[k]   <= '0;
         end
      end else begin
         vreq_q <= iVgaVRequest;
         done_q <= 1'b0;
         case (state)
            START_UP: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  run_q[k]   <= '0;
                  max_q[k]   <= '0;
                  end_x_q[k] <= '0;
                  line_q[k]  <= DEF_Y;
               end
               if (iVgaVRequest && !vreq_q)
                  state <= WAIT;
            end
            WAIT: begin
               for (int k = 0; k < NUM_CH; k++)
                  run_q[k] <= '0;
               if (!iVgaVRequest) begin
                  state  <= START_UP;
                  done_q <= 1'b1;
                  for (int k = 0; k < NUM_CH; k++) begin
                     len_q[k] <= max_q[k];
                     if (max_q[k] >= MIN_LEN) begin
                        found_q[k] <= 1'b1;
                        cx_q[k]    <= end_x_q[k] - (max_q[k] >> 1);
                        cy_q[k]    <= line_q[k];
                     end else begin
                        found_q[k] <= 1'b0;
                        cx_q[k]    <= DEF_X;
                        cy_q[k]    <= DEF_Y;
                     end
                  end
               end else if (iVgaHRequest) begin
                  state <= ACTIVE;
               end
            end
            ACTIVE: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (iVgaHRequest) begin
                     run_q[k] <= run_nxt[k];
                     if (run_nxt[k] > max_q[k]) begin
                        max_q[k]   <= run_nxt[k];
                        end_x_q[k] <= rep_x;
                        line_q[k]  <= rep_y;
                     end
                  end else begin
                     run_q[k] <= '0;
                  end
               end
               if (!iVgaHRequest)
                  state <= WAIT;
            end
            default: state <= START_UP;
         endcase
      end
   end

   assign oCenterX   = cx_q;
   assign oCenterY   = cy_q;
   assign oRunLen    = len_q;
   assign oFound     = found_q;
   assign oFrameDone = done_q;

endmodule

// File: tb/tb_color_blob_tracker.sv
// Frame-level bench for color_blob_tracker: images are built in an array, the reference
// filters them with plain 3x3 neighbourhood sums and scans for the longest run per line.
module tb_color_blob_tracker;

   localparam int NUM_CH = 2;
   localparam int H      = 64;
   localparam int V      = 40;
   localparam int THR    = 5;
   localparam int MINR   = 4;
   localparam int HBLANK = 3;

   logic                 iVgaClk = 1'b0;
   logic                 reset;
   logic [NUM_CH-1:0]    iMask;
   logic [9:0]           iHIndex;
   logic [8:0]           iVIndex;
   logic                 iVgaHRequest;
   logic                 iVgaVRequest;
   logic [NUM_CH-1:0]    iFilterOn;
   logic [NUM_CH-1:0]    oFiltMask;
   logic [10*NUM_CH-1:0] oCenterX;
   logic [9*NUM_CH-1:0]  oCenterY;
   logic [10*NUM_CH-1:0] oRunLen;
   logic [NUM_CH-1:0]    oFound;
   logic                 oFrameDone;

   always #5 iVgaClk = ~iVgaClk;

   color_blob_tracker #(
      .NUM_CH      (NUM_CH),
      .H_ACTIVE    (H),
      .V_ACTIVE    (V),
      .VOTE_THRESH (THR),
      .MIN_RUN     (MINR)
   ) dut (
      .iVgaClk      (iVgaClk),
      .reset        (reset),
      .iMask        (iMask),
      .iHIndex      (iHIndex),
      .iVIndex      (iVIndex),
      .iVgaHRequest (iVgaHRequest),
      .iVgaVRequest (iVgaVRequest),
      .iFilterOn    (iFilterOn),
      .oFiltMask    (oFiltMask),
      .oCenterX     (oCenterX),
      .oCenterY     (oCenterY),
      .oRunLen      (oRunLen),
      .oFound       (oFound),
      .oFrameDone   (oFrameDone)
   );

   bit                pix [NUM_CH][V][H];
   logic [NUM_CH-1:0] fon;
   int                e_len [NUM_CH];
   int                e_cx  [NUM_CH];
   int                e_cy  [NUM_CH];
   int                e_fnd [NUM_CH];
   int                vectors     = 0;
   int                miscompares = 0;
   int                done_cnt    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge iVgaClk);
      if (oFrameDone === 1'b1) done_cnt++;
   endtask

   // Filtered value of image pixel (cx,cy) in channel k.
   function automatic bit filt_model(input int k, input int cx, input int cy);
      int s;
      if (cy < 0) return 1'b0;
      if (!fon[k]) return pix[k][cy][cx];
      s = 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++)
            if (cx + dx >= 2 && cy + dy >= 2 && cx + dx < H && cy + dy < V)
               s += int'(pix[k][cy+dy][cx+dx]);
      return s >= THR;
   endfunction

   // Longest run of filtered pixels; earliest wins ties, runs end at line ends.
   task automatic compute_expected();
      for (int k = 0; k < NUM_CH; k++) begin
         int mx, ex, ln, run;
         mx = 0; ex = 0; ln = V / 2;
         for (int cy = 0; cy <= V - 2; cy++) begin
            run = 0;
            for (int cx = 0; cx <= H - 2; cx++) begin
               run = filt_model(k, cx, cy) ? run + 1 : 0;
               if (run > mx) begin
                  mx = run; ex = cx; ln = cy;
               end
            end
         end
         e_len[k] = mx;
         e_fnd[k] = (mx >= MINR) ? 1 : 0;
         e_cx[k]  = (mx >= MINR) ? ex - mx / 2 : H / 2;
         e_cy[k]  = (mx >= MINR) ? ln : V / 2;
      end
   endtask

   task automatic clear_img();
      foreach (pix[k, y, x]) pix[k][y][x] = 1'b0;
   endtask

   task automatic rect(input int k, input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            if (x >= 0 && x < H && y >= 0 && y < V) pix[k][y][x] = 1'b1;
   endtask

   task automatic random_img();
      clear_img();
      for (int k = 0; k < NUM_CH; k++) begin
         int n;
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) begin
            int x0, y0;
            x0 = int'($urandom_range(0, H - 1));
            y0 = int'($urandom_range(0, V - 1));
            rect(k, x0, x0 + int'($urandom_range(0, 30)), y0, y0 + int'($urandom_range(0, 12)));
         end
         foreach (pix[k, y, x]) if ($urandom_range(0, 19) == 0) pix[k][y][x] = ~pix[k][y][x];
      end
      fon = NUM_CH'($urandom);
   endtask

   task automatic check_defaults(input string tag);
      for (int k = 0; k < NUM_CH; k++) begin
         check($sformatf("%s_cx%0d", tag, k), 32'(oCenterX[10*k +: 10]), H / 2);
         check($sformatf("%s_cy%0d", tag, k), 32'(oCenterY[9*k +: 9]), V / 2);
         check($sformatf("%s_len%0d", tag, k), 32'(oRunLen[10*k +: 10]), 0);
         check($sformatf("%s_fnd%0d", tag, k), 32'(oFound[k]), 0);
      end
      check($sformatf("%s_done", tag), 32'(oFrameDone), 0);
   endtask

   // Drives one frame of pix; rst_v/rst_h place a one-cycle reset (negative for none).
   task automatic run_frame(input string name, input int rst_v, input int rst_h);
      bit got_reset;
      got_reset = (rst_v >= 0);
      compute_expected();
      done_cnt = 0;
      iFilterOn = fon;
      iVgaVRequest = 1'b1; iVgaHRequest = 1'b0; iMask = '0; iHIndex = '0; iVIndex = '0;
      repeat (2) tick();
      for (int v = 0; v < V; v++) begin
         for (int b = 0; b < HBLANK; b++) begin
            tick();
            iVgaHRequest = 1'b0; iMask = '0; iHIndex = '0; iVIndex = 9'(v);
         end
         for (int h = 0; h < H; h++) begin
            tick();
            if (reset) begin
               reset = 1'b0;
               check_defaults({name, "_rst"});
            end
            if (v == rst_v && h == rst_h) reset = 1'b1;
            iVgaHRequest = 1'b1; iHIndex = 10'(h); iVIndex = 9'(v);
            for (int k = 0; k < NUM_CH; k++) iMask[k] = pix[k][v][h];
            #1;
            if (h >= 1)
               for (int k = 0; k < NUM_CH; k++)
                  check($sformatf("%s_filt%0d_x%0d_y%0d", name, k, h - 1, v - 1),
                        32'(oFiltMask[k]), int'(filt_model(k, h - 1, v - 1)));
         end
      end
      repeat (2) begin
         tick();
         iVgaHRequest = 1'b0; iMask = '0;
      end
      check({name, "_early_done"}, done_cnt, 0);
      tick();
      iVgaVRequest = 1'b0;
      for (int i = 0; i < 10 && done_cnt == 0; i++) tick();
      if (got_reset) begin
         check({name, "_no_done"}, done_cnt, 0);
      end else begin
         check({name, "_done"}, done_cnt, 1);
         for (int k = 0; k < NUM_CH; k++) begin
            check($sformatf("%s_cx%0d", name, k), 32'(oCenterX[10*k +: 10]), e_cx[k]);
            check($sformatf("%s_cy%0d", name, k), 32'(oCenterY[9*k +: 9]), e_cy[k]);
            check($sformatf("%s_len%0d", name, k), 32'(oRunLen[10*k +: 10]), e_len[k]);
            check($sformatf("%s_fnd%0d", name, k), 32'(oFound[k]), e_fnd[k]);
         end
         tick();
         check({name, "_done_pulse"}, 32'(oFrameDone), 0);
      end
      repeat (3) tick();
   endtask

   initial begin
      reset = 1'b1; iMask = '0; iHIndex = '0; iVIndex = '0;
      iVgaHRequest = 1'b0; iVgaVRequest = 1'b0; iFilterOn = '0; fon = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_defaults("reset");

      clear_img(); fon = 2'b11;
      run_frame("blank", -1, -1);

      clear_img(); fon = 2'b11; rect(0, 20, 39, 10, 19);
      run_frame("rect", -1, -1);

      clear_img(); fon = 2'b11; pix[0][10][10] = 1'b1;
      run_frame("noise_on", -1, -1);
      fon = 2'b00;
      run_frame("noise_off", -1, -1);

      clear_img(); fon = 2'b00; rect(0, 5, 24, 8, 8); rect(0, 30, 49, 30, 30);
      run_frame("tie", -1, -1);

      clear_img(); fon = 2'b11; rect(0, 8, 15, 5, 12); rect(1, 45, 52, 20, 27);
      run_frame("two_ch", -1, -1);

      clear_img(); fon = 2'b01; rect(0, 0, H - 1, 0, V - 1); rect(1, 0, H - 1, 0, V - 1);
      run_frame("full", -1, -1);

      for (int i = 0; i < 3; i++) begin
         random_img();
         run_frame($sformatf("rand%0d", i), -1, -1);
      end

      random_img();
      run_frame("mid_reset", 15, 30);
      run_frame("after_reset", -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
